lp_filter_reader: RTL and testbench
===================================

Name: lp_filter_reader

Overview:
- Consumer stage that sits downstream of the lp_filter_stage cascade.
- Takes the filtered sample stream (IN_VALUE qualified by CE) and decimates it by a power-of-two factor using boxcar averaging.
- Buffers averaged results in a small FIFO and hands them to the register/CPU side over a valid/ready handshake.
- Flags any results lost because the reader side stalled.

Parameters:
- DATA_BITS, 30: width of input samples and averaged output.
- SHIFT_BITS, 4: width of DECIM_SHIFT. Decimation factor N = 2^DECIM_SHIFT, max 2^(2^SHIFT_BITS − 1).
- FIFO_DEPTH, 4: number of averaged results buffered. Power of two, ≥2.

Ports:
- CLK, in, 1: system clock, rising edge.
- RESET, in, 1: asynchronous, active-low reset.
- CE, in, 1: input sample strobe; IN_VALUE is valid when high.
- IN_VALUE, in, DATA_BITS: filtered sample, unsigned.
- DECIM_SHIFT, in, SHIFT_BITS: log2 of the decimation factor.
- OUT_VALUE, out, DATA_BITS: averaged sample at the FIFO head.
- OUT_VALID, out, 1: FIFO not empty.
- OUT_READY, in, 1: consumer accepts OUT_VALUE when high together with OUT_VALID.
- OVERFLOW, out, 1: sticky flag; an averaged result was dropped.
- CLEAR_OVF, in, 1: clears OVERFLOW.
- FILL, out, clog2(FIFO_DEPTH)+1: FIFO occupancy.

Behaviour:
- Reset (RESET=0, asynchronous):
  - state=IDLE; accumulator, sample counter and shift_r cleared.
  - FIFO emptied.
  - Outputs: OUT_VALID=0, OUT_VALUE=0, OVERFLOW=0, FILL=0.
  - Reset asserted mid-window discards the partial sum; no output is produced from it.
- Accumulator:
  - Width DATA_BITS + 2^SHIFT_BITS − 1 bits, unsigned, so it never wraps.
  - Sample counter has the same width as the maximum N.
- FSM, two states:
  - IDLE: on CE, latch shift_r ← DECIM_SHIFT, acc ← IN_VALUE, cnt ← 1.
    - If DECIM_SHIFT=0, the window completes on that same CE; stay in IDLE.
    - Otherwise go to ACCUM.
  - ACCUM: on CE, acc ← acc + IN_VALUE, cnt ← cnt + 1.
    - When cnt+1 == 2^shift_r, the window completes; return to IDLE.
  - CE=0 cycles leave all state unchanged.
- DECIM_SHIFT is sampled only at window start. Changes mid-window take effect at the next window.
- Window completion:
  - result = (acc + IN_VALUE) >> shift_r, truncating; low DATA_BITS bits kept.
  - result is pushed into the FIFO at the same clock edge.
  - Latency: OUT_VALID rises in the cycle after the completing CE when the FIFO was empty.
- FIFO:
  - First-word-fall-through: OUT_VALUE = head entry whenever OUT_VALID=1. OUT_VALUE=0 when empty.
  - Pop happens on OUT_VALID & OUT_READY.
  - OUT_READY while empty has no effect.
  - Push when full without a simultaneous pop: result dropped, FIFO contents unchanged, OVERFLOW ← 1.
  - Push when full with a simultaneous pop: both succeed, FILL unchanged, no overflow.
  - Simultaneous push and pop when not full: FILL unchanged, order preserved.
- OVERFLOW:
  - CLEAR_OVF clears it on the next edge.
  - A new drop in the same cycle as CLEAR_OVF wins: OVERFLOW stays 1.
- Read/write pointers wrap modulo FIFO_DEPTH.
- FILL = write count minus read count, range 0..FIFO_DEPTH.

Test Plan:
- DECIM_SHIFT=2, IN_VALUE=1000 constant, CE every cycle, OUT_READY=1 -> OUT_VALUE=1000, OUT_VALID pulses once per 4 CE, first rising 1 cycle after the 4th CE.
- DECIM_SHIFT=2, IN_VALUE sequence 1,2,3,4, CE every other cycle -> single output 2 (10>>2). CE-low cycles do not advance the count.
- DECIM_SHIFT=0, OUT_READY=0, IN_VALUE=10,20,30,40,50 -> FILL goes 1..4 and stays at 4; OVERFLOW=1 after the 5th CE; draining yields 10,20,30,40. CLEAR_OVF then clears OVERFLOW.
- FIFO full (FILL=4), push and OUT_READY=1 in the same cycle -> OVERFLOW stays 0, FILL stays 4, popped entry is the oldest, new value enters at the tail.
- DECIM_SHIFT=15, IN_VALUE=2^30−1 constant for 32768 CEs -> OUT_VALUE=2^30−1 (no accumulator wrap). Change DECIM_SHIFT to 1 mid-window -> current window still uses 32768 samples; the next window uses 2.
- RESET pulled low after 3 of 4 samples (DECIM_SHIFT=2), released -> OUT_VALID=0, FILL=0. The next 4 CEs of value 8 produce exactly one output of 8.

Source files
------------

// File: rtl/lp_filter_reader_if.sv
// lp_filter_reader_if: sample input, averaged output handshake and status bundle for lp_filter_reader
interface lp_filter_reader_if #(
    parameter int DATA_BITS  = 30,
    parameter int SHIFT_BITS = 4,
    parameter int FIFO_DEPTH = 4
);
    logic                          i_ce;
    logic [DATA_BITS-1:0]          i_value;
    logic [SHIFT_BITS-1:0]         i_decim_shift;
    logic                          i_ready;
    logic                          i_clear_ovf;
    logic [DATA_BITS-1:0]          o_value;
    logic                          o_valid;
    logic                          o_overflow;
    logic [$clog2(FIFO_DEPTH):0]   o_fill;

    modport slave (
        input  i_ce, i_value, i_decim_shift, i_ready, i_clear_ovf,
        output o_value, o_valid, o_overflow, o_fill
    );

    modport master (
        output i_ce, i_value, i_decim_shift, i_ready, i_clear_ovf,
        input  o_value, o_valid, o_overflow, o_fill
    );
endinterface

// File: rtl/lp_filter_reader.sv
// lp_filter_reader: power-of-two boxcar decimator feeding a first-word-fall-through FIFO with sticky overflow
module lp_filter_reader #(
    parameter int DATA_BITS  = 30,
    parameter int SHIFT_BITS = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    lp_filter_reader_if.slave     bus
);
    localparam int ACC_W = DATA_BITS + 2**SHIFT_BITS - 1;
    localparam int CNT_W = 2**SHIFT_BITS;
    localparam int AW    = $clog2(FIFO_DEPTH);

    typedef enum logic {IDLE, ACCUM} state_t;

    state_t                r_state, w_next_state;
    logic [ACC_W-1:0]      r_acc, w_sum;
    logic [CNT_W-1:0]      r_cnt, w_cnt_inc;
    logic [SHIFT_BITS-1:0] r_shift, w_shift;
    logic                  w_done;
    logic [DATA_BITS-1:0]  w_result;
    logic [DATA_BITS-1:0]  r_mem [FIFO_DEPTH];
    logic [AW:0]           r_wr, r_rd, w_fill;
    logic                  w_full, w_pop, w_push, w_drop, r_ovf;

    // window state register; reset drops any partial window
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next_state;
    end

    // a completing sample always returns to IDLE, any other sample leaves us accumulating
    always_comb begin
        w_next_state = r_state;
        if (bus.i_ce) w_next_state = w_done ? IDLE : ACCUM;
    end

    // window arithmetic: the first sample of a window replaces the sum and latches the shift
    always_comb begin
        w_sum     = (r_state == IDLE ? '0 : r_acc) + ACC_W'(bus.i_value);
        w_shift   = r_state == IDLE ? bus.i_decim_shift : r_shift;
        w_cnt_inc = r_cnt + CNT_W'(1);
        w_done    = bus.i_ce && (r_state == IDLE ? bus.i_decim_shift == '0
                                                 : w_cnt_inc == (CNT_W'(1) << r_shift));
        w_result  = DATA_BITS'(w_sum >> w_shift);
    end

    // accumulator, sample counter and per-window shift advance only on CE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc   <= '0;
            r_cnt   <= '0;
            r_shift <= '0;
        end else if (bus.i_ce) begin
            r_acc <= w_sum;
            r_cnt <= r_state == IDLE ? CNT_W'(1) : w_cnt_inc;
            if (r_state == IDLE) r_shift <= bus.i_decim_shift;
        end
    end

    // a full FIFO still accepts a push when the head leaves in the same cycle
    always_comb begin
        w_fill = r_wr - r_rd;
        w_full = w_fill == (AW+1)'(FIFO_DEPTH);
        w_pop  = (w_fill != '0) && bus.i_ready;
        w_push = w_done && (!w_full || w_pop);
        w_drop = w_done && w_full && !w_pop;
    end

    // storage needs no reset: the pointers alone define which entries are live
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr[AW-1:0]] <= w_result;
    end

    // pointers carry one extra wrap bit so full and empty are distinguishable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr <= '0;
            r_rd <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + 1'b1;
            if (w_pop)  r_rd <= r_rd + 1'b1;
        end
    end

    // sticky overflow; a fresh drop beats a simultaneous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)               r_ovf <= 1'b0;
        else if (w_drop)          r_ovf <= 1'b1;
        else if (bus.i_clear_ovf) r_ovf <= 1'b0;
    end

    assign bus.o_valid    = w_fill != '0;
    assign bus.o_value    = bus.o_valid ? r_mem[r_rd[AW-1:0]] : '0;
    assign bus.o_fill     = w_fill;
    assign bus.o_overflow = r_ovf;
endmodule

// File: tb/tb_lp_filter_reader.sv
// tb_lp_filter_reader: directed stimulus with a scoreboard of expected averages for lp_filter_reader
module tb_lp_filter_reader;
    localparam int DB = 30;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic [DB-1:0] q[$];

    lp_filter_reader_if #(.DATA_BITS(DB), .SHIFT_BITS(4), .FIFO_DEPTH(4)) bus ();

    lp_filter_reader #(.DATA_BITS(DB), .SHIFT_BITS(4), .FIFO_DEPTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // every accepted output is compared against the oldest expected value
    always @(negedge clk) begin
        if (rst_n && bus.o_valid && bus.i_ready) begin
            logic [DB-1:0] exp;
            exp = q.size() > 0 ? q.pop_front() : 'x;
            n_checks++;
            assert (bus.o_value === exp) else begin
                n_fail++;
                $error("FAIL out_value: observed %0d expected %0d", bus.o_value, exp);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n             = 1'b0;
        bus.i_ce          = 1'b0;
        bus.i_value       = '0;
        bus.i_decim_shift = '0;
        bus.i_ready       = 1'b0;
        bus.i_clear_ovf   = 1'b0;
        #1;
        chk("rst_valid", bus.o_valid, 0);
        chk("rst_value", bus.o_value, 0);
        chk("rst_ovf", bus.o_overflow, 0);
        chk("rst_fill", bus.o_fill, 0);
        tick();
        rst_n = 1'b1;
        tick();

        // constant 1000, N=4, CE every cycle
        bus.i_ready = 1'b1;
        bus.i_decim_shift = 4'd2;
        bus.i_value = 1000;
        bus.i_ce = 1'b1;
        q.push_back(1000);
        q.push_back(1000);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t1_valid_early", bus.o_valid, 0);
        end
        tick();
        chk("t1_valid_rise", bus.o_valid, 1);
        tick();
        chk("t1_valid_pulse", bus.o_valid, 0);
        repeat (3) tick();
        bus.i_ce = 1'b0;
        repeat (3) tick();

        // ramp 1..4 with CE every other cycle
        q.push_back(2);
        for (int i = 1; i <= 4; i++) begin
            bus.i_ce = 1'b1;
            bus.i_value = DB'(i);
            tick();
            bus.i_ce = 1'b0;
            if (i == 3) chk("t2_no_early_out", bus.o_valid, 0);
            tick();
        end
        repeat (3) tick();

        // N=1, stalled reader fills the FIFO then drops
        bus.i_ready = 1'b0;
        bus.i_decim_shift = 4'd0;
        bus.i_ce = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            bus.i_value = DB'(10 * i);
            if (i <= 4) q.push_back(DB'(10 * i));
            tick();
            chk("t3_fill", bus.o_fill, i > 4 ? 4 : i);
            chk("t3_ovf", bus.o_overflow, i > 4);
        end
        bus.i_value = 60;
        bus.i_clear_ovf = 1'b1;
        tick();
        chk("t3_drop_beats_clear", bus.o_overflow, 1);
        bus.i_ce = 1'b0;
        bus.i_clear_ovf = 1'b0;
        bus.i_ready = 1'b1;
        repeat (4) tick();
        chk("t3_drained", bus.o_fill, 0);
        chk("t3_ovf_held", bus.o_overflow, 1);
        bus.i_clear_ovf = 1'b1;
        tick();
        bus.i_clear_ovf = 1'b0;
        chk("t3_ovf_cleared", bus.o_overflow, 0);

        // full FIFO with simultaneous push and pop
        bus.i_ready = 1'b0;
        bus.i_ce = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            bus.i_value = DB'(i);
            q.push_back(DB'(i));
            tick();
        end
        chk("t4_full", bus.o_fill, 4);
        bus.i_value = 5;
        q.push_back(5);
        bus.i_ready = 1'b1;
        tick();
        bus.i_ce = 1'b0;
        chk("t4_fill_kept", bus.o_fill, 4);
        chk("t4_no_ovf", bus.o_overflow, 0);
        chk("t4_new_head", bus.o_value, 2);
        repeat (5) tick();
        chk("t4_drained", bus.o_fill, 0);

        // N=32768 of full-scale input, shift change mid-window applies to the next window
        bus.i_decim_shift = 4'd15;
        bus.i_value = DB'((64'd1 << 30) - 1);
        q.push_back(DB'((64'd1 << 30) - 1));
        bus.i_ce = 1'b1;
        for (int i = 0; i < 32768; i++) begin
            if (i == 1) bus.i_decim_shift = 4'd1;
            tick();
        end
        chk("t5_wide_valid", bus.o_valid, 1);
        q.push_back(7);
        bus.i_value = 6;
        tick();
        bus.i_value = 9;
        tick();
        bus.i_ce = 1'b0;
        repeat (3) tick();
        chk("t5_drained", bus.o_fill, 0);

        // reset mid-window discards the partial sum
        bus.i_decim_shift = 4'd2;
        bus.i_value = 5;
        bus.i_ce = 1'b1;
        repeat (3) tick();
        bus.i_ce = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", bus.o_valid, 0);
        chk("t6_rst_fill", bus.o_fill, 0);
        rst_n = 1'b1;
        tick();
        bus.i_value = 8;
        bus.i_ce = 1'b1;
        q.push_back(8);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t6_no_early_out", bus.o_valid, 0);
        end
        tick();
        chk("t6_valid", bus.o_valid, 1);
        bus.i_ce = 1'b0;

        for (int i = 0; i < 20 && q.size() > 0; i++) tick();
        repeat (3) tick();
        chk("queue_empty", q.size(), 0);
        chk("final_fill", bus.o_fill, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
